// File: rtl/bram_load_scheduler.sv
// Round-robin scheduler sharing one read-only parameter BRAM among burst loaders.
// Issues one address per cycle and returns tagged bytes aligned with the 2-cycle read latency.
module bram_load_scheduler #(
   parameter int N_REQ      = 4,
   parameter int W          = 8,
   parameter int ADDR_WIDTH = 18,
   parameter int LEN_WIDTH  = 18,
   parameter int OWN_WIDTH  = $clog2(N_REQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*ADDR_WIDTH-1:0] req_base,
   input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
   output logic [N_REQ-1:0]            grant,
   output logic [N_REQ-1:0]            done,
   output logic                        bram_en,
   output logic                        bram_ren,
   output logic [ADDR_WIDTH-1:0]       bram_addr,
   input  logic [W-1:0]                bram_dout,
   output logic                        rd_valid,
   output logic [W-1:0]                rd_data,
   output logic [LEN_WIDTH-1:0]        rd_index,
   output logic [OWN_WIDTH-1:0]        rd_owner,
   output logic                        busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

   state_t                 state_r, state_s;
   logic [OWN_WIDTH-1:0]   rr_ptr_r, rr_ptr_s, owner_r, owner_s, pick_idx_s;
   logic [OWN_WIDTH:0]     scan_s;
   logic                   pick_found_s;
   logic [ADDR_WIDTH-1:0]  base_r, base_s, pick_base_s, bram_addr_r, bram_addr_s;
   logic [LEN_WIDTH-1:0]   len_r, len_s, pick_len_s, issue_cnt_r, issue_cnt_s, last_idx_s;
   logic [N_REQ-1:0]       grant_r, grant_s, done_r, done_s;
   logic                   bram_en_r, bram_en_s, bram_ren_r, bram_ren_s, busy_r;
   logic                   s1_valid_r, rd_valid_r;
   logic [LEN_WIDTH-1:0]   s1_index_r, rd_index_r;
   logic [OWN_WIDTH-1:0]   s1_owner_r, rd_owner_r;
   logic [W-1:0]           rd_data_s;

   assign last_idx_s = len_r - LEN_WIDTH'(1);

   // Round-robin search: first pending requester at or above rr_ptr, wrapping
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = '0;
      scan_s       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_s = {1'b0, rr_ptr_r} + (OWN_WIDTH+1)'(k);
         if (scan_s >= (OWN_WIDTH+1)'(N_REQ)) begin
            scan_s = scan_s - (OWN_WIDTH+1)'(N_REQ);
         end else begin
            scan_s = scan_s;
         end
         if (!pick_found_s && req[scan_s[OWN_WIDTH-1:0]]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = scan_s[OWN_WIDTH-1:0];
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Select the winning requester's burst descriptor
   always_comb begin
      pick_base_s = '0;
      pick_len_s  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx_s == OWN_WIDTH'(i)) begin
            pick_base_s = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
            pick_len_s  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
         end else begin
            pick_base_s = pick_base_s;
         end
      end
   end

   // Next-state and next-output logic; every output is registered from these values
   always_comb begin
      state_s     = state_r;
      rr_ptr_s    = rr_ptr_r;
      owner_s     = owner_r;
      base_s      = base_r;
      len_s       = len_r;
      issue_cnt_s = issue_cnt_r;
      grant_s     = grant_r;
      done_s      = '0;
      bram_en_s   = 1'b0;
      bram_ren_s  = 1'b0;
      bram_addr_s = bram_addr_r;
      case (state_r)
         IDLE: begin
            grant_s = '0;
            if (pick_found_s) begin
               owner_s             = pick_idx_s;
               base_s              = pick_base_s;
               len_s               = pick_len_s;
               issue_cnt_s         = '0;
               grant_s[pick_idx_s] = 1'b1;
               rr_ptr_s = (pick_idx_s == OWN_WIDTH'(N_REQ-1)) ? '0 : pick_idx_s + OWN_WIDTH'(1);
               if (pick_len_s != '0) begin
                  state_s     = ISSUE;
                  bram_en_s   = 1'b1;
                  bram_ren_s  = 1'b1;
                  bram_addr_s = pick_base_s;
               end else begin
                  state_s = FIN;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            bram_en_s = 1'b1;
            if (issue_cnt_r == last_idx_s) begin
               state_s = DRAIN;
            end else begin
               bram_ren_s  = 1'b1;
               issue_cnt_s = issue_cnt_r + LEN_WIDTH'(1);
               bram_addr_s = base_r + ADDR_WIDTH'(issue_cnt_s);
            end
         end
         DRAIN: begin
            if (rd_valid_r && (rd_index_r == last_idx_s)) begin
               state_s = FIN;
               done_s  = grant_r;
            end else begin
               bram_en_s = 1'b1;
            end
         end
         FIN: begin
            // A zero-length burst enters FIN straight from IDLE and pulses done one cycle later
            if (done_r != '0) begin
               state_s = IDLE;
               grant_s = '0;
            end else begin
               done_s = grant_r;
            end
         end
         default: begin
            state_s = IDLE;
            grant_s = '0;
         end
      endcase
   end

   // Control state and registered BRAM/handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         rr_ptr_r    <= '0;
         owner_r     <= '0;
         base_r      <= '0;
         len_r       <= '0;
         issue_cnt_r <= '0;
         grant_r     <= '0;
         done_r      <= '0;
         bram_en_r   <= 1'b0;
         bram_ren_r  <= 1'b0;
         bram_addr_r <= '0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         rr_ptr_r    <= rr_ptr_s;
         owner_r     <= owner_s;
         base_r      <= base_s;
         len_r       <= len_s;
         issue_cnt_r <= issue_cnt_s;
         grant_r     <= grant_s;
         done_r      <= done_s;
         bram_en_r   <= bram_en_s;
         bram_ren_r  <= bram_ren_s;
         bram_addr_r <= bram_addr_s;
         busy_r      <= (state_s != IDLE);
      end
   end

   // Two-stage tag pipeline matching the BRAM read latency
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_index_r <= '0;
         s1_owner_r <= '0;
         rd_valid_r <= 1'b0;
         rd_index_r <= '0;
         rd_owner_r <= '0;
      end else begin
         s1_valid_r <= bram_ren_r;
         s1_index_r <= issue_cnt_r;
         s1_owner_r <= owner_r;
         rd_valid_r <= s1_valid_r;
         rd_index_r <= s1_index_r;
         rd_owner_r <= s1_owner_r;
      end
   end

   // Data comes straight from the BRAM output register, masked outside valid beats
   always_comb begin
      if (rd_valid_r) begin
         rd_data_s = bram_dout;
      end else begin
         rd_data_s = '0;
      end
   end

   assign grant     = grant_r;
   assign done      = done_r;
   assign bram_en   = bram_en_r;
   assign bram_ren  = bram_ren_r;
   assign bram_addr = bram_addr_r;
   assign rd_valid  = rd_valid_r;
   assign rd_data   = rd_data_s;
   assign rd_index  = rd_index_r;
   assign rd_owner  = rd_owner_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_bram_load_scheduler.sv
// Bench for bram_load_scheduler: directed table, hand-written reset sequence and random bursts
// checked against a cycle timeline derived from burst length and a round-robin owner model.
module tb_bram_load_scheduler;
   localparam int N  = 4;
   localparam int AW = 18;
   localparam int LW = 18;
   localparam int OW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N*AW-1:0] req_base;
   logic [N*LW-1:0] req_len;
   logic [N-1:0]  grant, done;
   logic          bram_en, bram_ren, rd_valid, busy;
   logic [AW-1:0] bram_addr;
   logic [7:0]    bram_dout = 8'h00;
   logic [7:0]    p1 = 8'h00;
   logic [7:0]    rd_data;
   logic [LW-1:0] rd_index;
   logic [OW-1:0] rd_owner;

   int total = 0;
   int bad = 0;
   int model_rr = 0;

   always #5 clk = ~clk;

   bram_load_scheduler dut (
      .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_len(req_len),
      .grant(grant), .done(done), .bram_en(bram_en), .bram_ren(bram_ren),
      .bram_addr(bram_addr), .bram_dout(bram_dout), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_index(rd_index), .rd_owner(rd_owner), .busy(busy)
   );

   function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
      return a[7:0] ^ {a[17:16], a[13:8]} ^ 8'h5A;
   endfunction

   // BRAM preload with two register stages of read latency
   always @(posedge clk) begin
      if (bram_en) p1 <= mem_byte(bram_addr);
      bram_dout <= p1;
   end

   function automatic int pick(input logic [N-1:0] m, input int rr);
      for (int k = 0; k < N; k++) begin
         if (m[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int i, input logic [AW-1:0] b, input logic [LW-1:0] l);
      req_base[i*AW +: AW] = b;
      req_len[i*LW +: LW]  = l;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_ctl"}, {grant, done, busy, bram_en, bram_ren, rd_valid}, 64'd0);
      chk({name, "_tags"}, {bram_addr, rd_index, rd_owner, rd_data}, 64'd0);
   endtask

   // Called in the IDLE cycle t with inputs already set; checks cycles t+1 .. t+last+1
   task automatic run_one(input int owner, input logic [AW-1:0] base,
                          input logic [LW-1:0] len, input bit mutate);
      logic [N-1:0] oh;
      logic [11:0]  e_ctl;
      int           last, L;
      bit           inb, e_en, e_ren, e_vld;
      L    = int'(len);
      oh   = 4'b0001 << owner;
      last = (L == 0) ? 2 : L + 3;
      for (int k = 1; k <= last + 1; k++) begin
         tick;
         inb   = (k <= last);
         e_en  = (L != 0) && (k <= L + 2);
         e_ren = (L != 0) && (k <= L);
         e_vld = (L != 0) && (k >= 3) && (k <= L + 2);
         e_ctl = {inb ? oh : 4'b0000, (k == last) ? oh : 4'b0000, inb, e_en, e_ren, e_vld};
         chk("ctl", {grant, done, busy, bram_en, bram_ren, rd_valid}, 64'(e_ctl));
         if (e_ren) chk("addr", bram_addr, 64'(AW'(base + AW'(k - 1))));
         if (e_vld) begin
            chk("rd_index", rd_index, 64'(k - 3));
            chk("rd_owner", rd_owner, 64'(owner));
            chk("rd_data", rd_data, 64'(mem_byte(AW'(base + AW'(k - 3)))));
         end
         if (mutate && k == 1) begin
            req[owner] = 1'b0;
            set_slot(owner, ~base, LW'($urandom_range(1, 30)));
         end
      end
      model_rr = (owner + 1) % N;
   endtask

   typedef struct {
      logic [N-1:0]  req;
      logic [AW-1:0] base;
      logic [LW-1:0] len;
      bit            mutate;
      int            owner;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [AW-1:0] rb;
      logic [LW-1:0] rl;
      logic [N-1:0]  m;
      int            o;

      tbl[0]  = '{4'b1111, 18'd4096,   18'd2, 1'b0, 0};
      tbl[1]  = '{4'b1111, 18'd4096,   18'd2, 1'b0, 1};
      tbl[2]  = '{4'b1111, 18'd4096,   18'd2, 1'b0, 2};
      tbl[3]  = '{4'b1111, 18'd4096,   18'd2, 1'b0, 3};
      tbl[4]  = '{4'b1111, 18'd4096,   18'd2, 1'b0, 0};
      tbl[5]  = '{4'b0001, 18'd147472, 18'd8, 1'b0, 0};
      tbl[6]  = '{4'b0100, 18'd100,    18'd0, 1'b0, 2};
      tbl[7]  = '{4'b0010, 18'd262142, 18'd4, 1'b0, 1};
      tbl[8]  = '{4'b1000, 18'd5000,   18'd5, 1'b1, 3};
      tbl[9]  = '{4'b1001, 18'd50,     18'd1, 1'b0, 0};
      tbl[10] = '{4'b1001, 18'd50,     18'd1, 1'b0, 3};
      tbl[11] = '{4'b1001, 18'd50,     18'd1, 1'b0, 0};

      rst = 1'b1;
      req = '0;
      req_base = '0;
      req_len = '0;
      repeat (3) tick;
      chk_all_zero("reset");
      rst = 1'b0;
      model_rr = 0;

      for (int v = 0; v < 12; v++) begin
         req = tbl[v].req;
         for (int i = 0; i < N; i++) set_slot(i, tbl[v].base, tbl[v].len);
         run_one(tbl[v].owner, tbl[v].base, tbl[v].len, tbl[v].mutate);
      end

      // Reset asserted during the third ISSUE cycle of a 16-byte burst
      req = 4'b0001;
      set_slot(0, 18'd1000, 18'd16);
      tick;
      tick;
      tick;
      chk("mid_ren", {grant, bram_ren, bram_addr}, {4'b0001, 1'b1, 18'd1002});
      rst = 1'b1;
      req = '0;
      tick;
      chk_all_zero("after_rst");
      rst = 1'b0;
      model_rr = 0;
      for (int c = 0; c < 6; c++) begin
         tick;
         chk("quiet", {grant, done, busy, bram_en, bram_ren, rd_valid}, 64'd0);
      end
      req = 4'b0010;
      set_slot(1, 18'd777, 18'd3);
      run_one(1, 18'd777, 18'd3, 1'b0);

      // Random bursts against the round-robin owner model
      for (int r = 0; r < 40; r++) begin
         m = 4'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) begin
            rb = ($urandom_range(0, 3) == 0) ? AW'(262144 - $urandom_range(1, 4)) : AW'($urandom);
            set_slot(i, rb, LW'($urandom_range(0, 6)));
         end
         req = m;
         if (m == '0) begin
            tick;
            chk("idle", {grant, done, busy, bram_en, bram_ren, rd_valid}, 64'd0);
         end else begin
            o  = pick(m, model_rr);
            rb = req_base[o*AW +: AW];
            rl = req_len[o*LW +: LW];
            run_one(o, rb, rl, 1'($urandom_range(0, 1)));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bram_load_scheduler.md
# bram_load_scheduler

Shares the single read-only parameter BRAM between up to N_REQ weight/bias loader requesters. Each requester asks for a contiguous burst (base address, byte count). The block arbitrates round-robin, drives the BRAM read port, compensates the 2-cycle read latency and streams tagged bytes back to the owner. It sits between the per-layer loaders and the one BRAM instance, so loaders no longer instantiate BRAM themselves.

## Interface

Parameters:
- N_REQ, 4, number of requesters (≥2)
- W, 8, BRAM data width
- ADDR_WIDTH, 18, BRAM address width
- LEN_WIDTH, 18, burst length width (bytes)
- OWN_WIDTH, $clog2(N_REQ), owner index width

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request level; bit i belongs to requester i
- req_base  in  N_REQ*ADDR_WIDTH  start address of requester i, at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_len  in  N_REQ*LEN_WIDTH  byte count of requester i, at [i*LEN_WIDTH +: LEN_WIDTH]
- grant  out  N_REQ  one-hot owner of the BRAM, or all zero
- done  out  N_REQ  one-cycle pulse to the owner when its burst is complete
- bram_en  out  1  BRAM enable
- bram_ren  out  1  BRAM read enable; wen is tied 0 at the BRAM instance
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_dout  in  W  BRAM read data, valid 2 cycles after the address
- rd_valid  out  1  rd_data is valid this cycle
- rd_data  out  W  byte returned from BRAM
- rd_index  out  LEN_WIDTH  offset of rd_data within the burst (0..len-1)
- rd_owner  out  OWN_WIDTH  requester index the byte belongs to
- busy  out  1  high in every state except IDLE

## Operation

- FSM states are IDLE, ISSUE, DRAIN and FIN.
- IDLE:
  - If any req bit is high, select the first set bit searching upward from rr_ptr, wrapping at N_REQ.
  - Latch that requester's req_base and req_len, assert grant, and set rr_ptr to owner+1 mod N_REQ.
  - Go to ISSUE if len>0, otherwise go to FIN.
- ISSUE:
  - bram_en=bram_ren=1 and bram_addr=base+issue_cnt, with addition mod 2^ADDR_WIDTH (wraps silently).
  - issue_cnt increments each cycle.
  - When issue_cnt reaches len-1 in a cycle, go to DRAIN.
- DRAIN:
  - bram_ren=0 and bram_en=1.
  - Stay until the last byte (index len-1) has been presented on rd_valid, then go to FIN.
- FIN:
  - done[owner]=1 and grant is still asserted.
  - Next cycle: grant=0, go to IDLE.
- Return path:
  - A 2-stage valid/index shift register tracks issued reads.
  - rd_valid, rd_index and rd_owner are registered and aligned with bram_dout, so rd_data = bram_dout in the rd_valid cycle.
- Requester rules:
  - Inputs are latched at grant; later changes to req_base, req_len or req are ignored until FIN.
  - A req dropped mid-burst does not abort the burst.
  - A req still high in the IDLE cycle after FIN is eligible again, but other pending requesters win because of rr_ptr.
- Reset:
  - Takes effect on any cycle, including mid-burst.
  - Outputs go to: grant=0, done=0, bram_en=0, bram_ren=0, bram_addr=0, rd_valid=0, rd_data=0, rd_index=0, rd_owner=0, busy=0.
  - Internal state: rr_ptr=0, FSM=IDLE, pipeline valids cleared.
  - In-flight BRAM data is discarded.

## Timing

- Let t be the IDLE cycle in which req is sampled high.
  - grant and busy rise at t+1, together with the first address and bram_ren.
  - Addresses are base..base+len-1 on cycles t+1..t+len.
  - rd_valid is high on cycles t+3..t+len+2 with rd_index 0..len-1, back to back with no bubbles.
  - DRAIN covers cycles t+len+1..t+len+2.
  - done pulses at t+len+3.
  - grant and busy fall at t+len+4, the IDLE cycle.
  - The next grant is at t+len+5 at the earliest.
- Zero-length burst: grant at t+1, FIN with a done pulse at t+2, IDLE at t+3. No BRAM access and no rd_valid.
- Throughput is 1 byte/cycle within a burst. Overhead is 4 cycles per burst.
- grant is never all-ones and never changes owner except through IDLE.
- done is always a subset of grant.

## Test plan

- Single burst: req[0]=1, base=147472, len=8.
  - Required: bram_addr=147472..147479 on consecutive cycles.
  - Required: 8 rd_valid cycles, rd_index 0..7 matching BRAM preload, rd_owner=0.
  - Required: done[0] 3 cycles after the last address.
- Round-robin: req=4'b1111 held high, each len=2.
  - Required: grant order 0,1,2,3,0.
  - Required: no overlap of rd_valid between owners, and exactly one done per burst.
- Zero length: req[2]=1, len=0.
  - Required: grant[2] for 2 cycles, done[2] on the second, bram_ren never asserted, rd_valid never asserted.
- Address wrap: base=2^18-2, len=4.
  - Required: addresses 262142, 262143, 0, 1.
  - Required: rd_index 0..3 correct.
- Reset mid-burst: rst on the 3rd ISSUE cycle of len=16.
  - Required: every output zero the next cycle, and no stale rd_valid afterwards.
  - Required: a new req[1] afterwards is granted normally.
- req drop plus input change mid-burst: req[3] deasserted and req_base changed after grant, len=5.
  - Required: all 5 bytes are still delivered from the original base, then done[3] pulses.
